// File: rtl/oc_bank_arbiter.sv
// oc_bank_arbiter
// Register-bank responder for the operand collectors. The 32x32 register file
// is split into four banks by reg_id[4:3]. Each collector slot posts a read
// request, each bank picks one pending slot per cycle in round-robin order,
// and the result goes out on that bank's broadcast bus. A writeback takes
// its bank for the cycle, so any read of that bank waits one cycle and then
// sees the new value.
module oc_bank_arbiter #(
   parameter int NUM_OC = 4,
   parameter int SLOT_W = 3
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [2*NUM_OC-1:0]     req_vld,
   input  logic [5*2*NUM_OC-1:0]   req_reg_id,
   input  logic                    wb_en,
   input  logic [4:0]              wb_reg_id,
   input  logic [31:0]             wb_data,
   output logic [31:0]             bk_0_data,
   output logic                    bk_0_vld,
   output logic [SLOT_W-1:0]       bk_0_ocid,
   output logic                    bk_0_bz,
   output logic [31:0]             bk_1_data,
   output logic                    bk_1_vld,
   output logic [SLOT_W-1:0]       bk_1_ocid,
   output logic                    bk_1_bz,
   output logic [31:0]             bk_2_data,
   output logic                    bk_2_vld,
   output logic [SLOT_W-1:0]       bk_2_ocid,
   output logic                    bk_2_bz,
   output logic [31:0]             bk_3_data,
   output logic                    bk_3_vld,
   output logic [SLOT_W-1:0]       bk_3_ocid,
   output logic                    bk_3_bz,
   output logic [2*NUM_OC-1:0]     pending
);

   localparam int NUM_SLOTS = 2 * NUM_OC;
   localparam int NUM_BANKS = 4;

   logic [4:0]        reg_id_q   [NUM_SLOTS];
   logic [SLOT_W-1:0] ptr_q      [NUM_BANKS];
   logic [31:0]       rf         [32];

   logic [31:0]       bk_data_q  [NUM_BANKS];
   logic [SLOT_W-1:0] bk_ocid_q  [NUM_BANKS];
   logic [NUM_BANKS-1:0] bk_vld_q;
   logic [NUM_BANKS-1:0] bk_bz_q;

   logic [NUM_BANKS-1:0] bank_busy;
   logic [NUM_BANKS-1:0] grant_vld;
   logic [SLOT_W-1:0]    grant_slot [NUM_BANKS];
   logic [31:0]          grant_data [NUM_BANKS];
   logic [NUM_SLOTS-1:0] grant_clr;
   logic [NUM_SLOTS-1:0] cand       [NUM_BANKS];
   logic [SLOT_W:0]      pick       [NUM_BANKS];

   // Round-robin search: first set bit of cand at or above ptr, wrapping.
   // The MSB of the result flags that a candidate was found.
   function automatic logic [SLOT_W:0] rr_pick(input logic [NUM_SLOTS-1:0] c,
                                               input logic [SLOT_W-1:0] ptr);
      logic [SLOT_W:0]   result;
      logic [SLOT_W-1:0] idx;
      result = '0;
      for (int i = 0; i < NUM_SLOTS; i++) begin
         idx = SLOT_W'((int'(ptr) + i) % NUM_SLOTS);
         if (!result[SLOT_W] && c[idx]) begin
            result = {1'b1, idx};
         end
      end
      return result;
   endfunction

   // Per-bank candidate selection; a bank being written this cycle grants nothing.
   always_comb begin
      bank_busy  = '0;
      grant_vld  = '0;
      grant_clr  = '0;
      grant_slot = '{default: '0};
      grant_data = '{default: '0};
      cand       = '{default: '0};
      pick       = '{default: '0};
      for (int b = 0; b < NUM_BANKS; b++) begin
         bank_busy[b] = wb_en && (wb_reg_id[4:3] == 2'(b));
         for (int s = 0; s < NUM_SLOTS; s++) begin
            cand[b][s] = pending[s] && (reg_id_q[s][4:3] == 2'(b));
         end
         pick[b]       = rr_pick(cand[b], ptr_q[b]);
         grant_vld[b]  = pick[b][SLOT_W] && !bank_busy[b];
         grant_slot[b] = pick[b][SLOT_W-1:0];
         grant_data[b] = rf[reg_id_q[grant_slot[b]]];
         if (grant_vld[b]) begin
            grant_clr[grant_slot[b]] = 1'b1;
         end
      end
   end

   // Request capture: a new request always wins over a same-edge grant clear.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pending  <= '0;
         reg_id_q <= '{default: '0};
      end else begin
         pending <= (pending & ~grant_clr) | req_vld;
         for (int s = 0; s < NUM_SLOTS; s++) begin
            if (req_vld[s]) begin
               reg_id_q[s] <= req_reg_id[5*s +: 5];
            end
         end
      end
   end

   // Grant results onto the bank buses and advance the round-robin pointers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ptr_q     <= '{default: '0};
         bk_data_q <= '{default: '0};
         bk_ocid_q <= '{default: '0};
         bk_vld_q  <= '0;
         bk_bz_q   <= '0;
      end else begin
         bk_vld_q <= grant_vld;
         bk_bz_q  <= bank_busy;
         for (int b = 0; b < NUM_BANKS; b++) begin
            if (grant_vld[b]) begin
               ptr_q[b]     <= SLOT_W'((int'(grant_slot[b]) + 1) % NUM_SLOTS);
               bk_ocid_q[b] <= grant_slot[b];
               bk_data_q[b] <= grant_data[b];
            end
         end
      end
   end

   // Register file writeback.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rf <= '{default: '0};
      end else if (wb_en) begin
         rf[wb_reg_id] <= wb_data;
      end
   end

   assign bk_0_data = bk_data_q[0];
   assign bk_0_vld  = bk_vld_q[0];
   assign bk_0_ocid = bk_ocid_q[0];
   assign bk_0_bz   = bk_bz_q[0];
   assign bk_1_data = bk_data_q[1];
   assign bk_1_vld  = bk_vld_q[1];
   assign bk_1_ocid = bk_ocid_q[1];
   assign bk_1_bz   = bk_bz_q[1];
   assign bk_2_data = bk_data_q[2];
   assign bk_2_vld  = bk_vld_q[2];
   assign bk_2_ocid = bk_ocid_q[2];
   assign bk_2_bz   = bk_bz_q[2];
   assign bk_3_data = bk_data_q[3];
   assign bk_3_vld  = bk_vld_q[3];
   assign bk_3_ocid = bk_ocid_q[3];
   assign bk_3_bz   = bk_bz_q[3];

endmodule

// File: tb/tb_oc_bank_arbiter.sv
// tb_oc_bank_arbiter
// Directed bench for oc_bank_arbiter with hand-computed expected values.
module tb_oc_bank_arbiter;

   localparam int NUM_OC = 4;
   localparam int SLOT_W = 3;

   logic                  clk;
   logic                  rst;
   logic [2*NUM_OC-1:0]   req_vld;
   logic [5*2*NUM_OC-1:0] req_reg_id;
   logic                  wb_en;
   logic [4:0]            wb_reg_id;
   logic [31:0]           wb_data;
   logic [31:0]           bk_data [4];
   logic [3:0]            bk_vld;
   logic [SLOT_W-1:0]     bk_ocid [4];
   logic [3:0]            bk_bz;
   logic [2*NUM_OC-1:0]   pending;

   int checks = 0;
   int errors = 0;

   oc_bank_arbiter #(.NUM_OC(NUM_OC), .SLOT_W(SLOT_W)) dut (
      .clk(clk), .rst(rst),
      .req_vld(req_vld), .req_reg_id(req_reg_id),
      .wb_en(wb_en), .wb_reg_id(wb_reg_id), .wb_data(wb_data),
      .bk_0_data(bk_data[0]), .bk_0_vld(bk_vld[0]), .bk_0_ocid(bk_ocid[0]), .bk_0_bz(bk_bz[0]),
      .bk_1_data(bk_data[1]), .bk_1_vld(bk_vld[1]), .bk_1_ocid(bk_ocid[1]), .bk_1_bz(bk_bz[1]),
      .bk_2_data(bk_data[2]), .bk_2_vld(bk_vld[2]), .bk_2_ocid(bk_ocid[2]), .bk_2_bz(bk_bz[2]),
      .bk_3_data(bk_data[3]), .bk_3_vld(bk_vld[3]), .bk_3_ocid(bk_ocid[3]), .bk_3_bz(bk_bz[3]),
      .pending(pending)
   );

   // Free-running 10-unit clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Single comparison point: counts every check and reports mismatches.
   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", tag, actual, expected);
      end
   endtask

   // Checks all four outputs of one bank.
   task automatic checkBank(input string tag, input int b, input logic vld, input logic bz,
                            input logic [SLOT_W-1:0] ocid, input logic [31:0] data);
      checkOutput({tag, "_vld"},  32'(bk_vld[b]),  32'(vld));
      checkOutput({tag, "_bz"},   32'(bk_bz[b]),   32'(bz));
      checkOutput({tag, "_ocid"}, 32'(bk_ocid[b]), 32'(ocid));
      checkOutput({tag, "_data"}, bk_data[b],      data);
   endtask

   // Queue a read request on one slot for the next edge.
   task automatic setReq(input int slot, input logic [4:0] reg_id);
      req_vld[slot] = 1'b1;
      req_reg_id[5*slot +: 5] = reg_id;
   endtask

   // Queue a writeback for the next edge.
   task automatic setWrite(input logic [4:0] reg_id, input logic [31:0] data);
      wb_en     = 1'b1;
      wb_reg_id = reg_id;
      wb_data   = data;
   endtask

   // Pass the queued inputs through one clock edge, then drop all strobes.
   // Outputs are stable 1 unit after the edge when this returns.
   task automatic applyStimulus();
      @(posedge clk);
      #1;
      req_vld = '0;
      wb_en   = 1'b0;
   endtask

   // Directed scenario sequence.
   initial begin
      rst        = 1'b0;
      req_vld    = '0;
      req_reg_id = '0;
      wb_en      = 1'b0;
      wb_reg_id  = '0;
      wb_data    = '0;
      repeat (3) applyStimulus();

      // Reset state
      checkOutput("rst_pending", 32'(pending), 32'h0);
      for (int b = 0; b < 4; b++) checkBank("rst_bank", b, 1'b0, 1'b0, 3'd0, 32'h0);
      rst = 1'b1;

      // Writeback then read: slot 3 reads R9 two cycles later on bank 1
      setWrite(5'd9, 32'hDEADBEEF);
      applyStimulus();
      setReq(3, 5'd9);
      applyStimulus();
      checkOutput("t2_pending_set", 32'(pending), 32'h08);
      checkOutput("t2_early_vld", 32'(bk_vld[1]), 32'h0);
      applyStimulus();
      checkBank("t2_ret", 1, 1'b1, 1'b0, 3'd3, 32'hDEADBEEF);
      checkOutput("t2_pending_clr", 32'(pending), 32'h0);
      applyStimulus();
      checkBank("t2_hold", 1, 1'b0, 1'b0, 3'd3, 32'hDEADBEEF);

      // Round-robin within bank 2: slots 0,2,5 then 0,7 starting at ptr 6
      setWrite(5'd16, 32'hB0);  applyStimulus();
      setWrite(5'd17, 32'hC1);  applyStimulus();
      setWrite(5'd18, 32'hC2);  applyStimulus();
      setReq(0, 5'd16); setReq(2, 5'd17); setReq(5, 5'd18);
      applyStimulus();
      checkOutput("t3_pending", 32'(pending), 32'h25);
      applyStimulus();
      checkBank("t3_g0", 2, 1'b1, 1'b0, 3'd0, 32'hB0);
      applyStimulus();
      checkBank("t3_g2", 2, 1'b1, 1'b0, 3'd2, 32'hC1);
      applyStimulus();
      checkBank("t3_g5", 2, 1'b1, 1'b0, 3'd5, 32'hC2);
      checkOutput("t3_pending_done", 32'(pending), 32'h0);
      setReq(0, 5'd16); setReq(7, 5'd17);
      applyStimulus();
      applyStimulus();
      checkBank("t3_r2_first", 2, 1'b1, 1'b0, 3'd7, 32'hC1);
      applyStimulus();
      checkBank("t3_r2_second", 2, 1'b1, 1'b0, 3'd0, 32'hB0);

      // All four banks return in the same cycle
      setWrite(5'd0,  32'hA0);  applyStimulus();
      setWrite(5'd8,  32'hA8);  applyStimulus();
      setWrite(5'd24, 32'hB8);  applyStimulus();
      setReq(0, 5'd0); setReq(1, 5'd8); setReq(2, 5'd16); setReq(3, 5'd24);
      applyStimulus();
      applyStimulus();
      checkBank("t4_b0", 0, 1'b1, 1'b0, 3'd0, 32'hA0);
      checkBank("t4_b1", 1, 1'b1, 1'b0, 3'd1, 32'hA8);
      checkBank("t4_b2", 2, 1'b1, 1'b0, 3'd2, 32'hB0);
      checkBank("t4_b3", 3, 1'b1, 1'b0, 3'd3, 32'hB8);

      // Write to bank 1 in the grant cycle defers the read by one cycle
      setWrite(5'd12, 32'h12121212);
      applyStimulus();
      setReq(1, 5'd12);
      applyStimulus();
      setWrite(5'd13, 32'h13131313);
      applyStimulus();
      checkBank("t5_busy", 1, 1'b0, 1'b1, 3'd1, 32'hA8);
      checkOutput("t5_still_pending", 32'(pending), 32'h02);
      applyStimulus();
      checkBank("t5_ret", 1, 1'b1, 1'b0, 3'd1, 32'h12121212);

      // Same-edge write/request on R4, then a second write: data must be 7
      setWrite(5'd4, 32'd5); setReq(4, 5'd4);
      applyStimulus();
      setWrite(5'd4, 32'd7);
      applyStimulus();
      checkBank("t6_busy", 0, 1'b0, 1'b1, 3'd0, 32'hA0);
      applyStimulus();
      checkBank("t6_ret", 0, 1'b1, 1'b0, 3'd4, 32'd7);

      // Re-request on a pending slot: only the new id is returned
      setWrite(5'd1, 32'h0101);
      applyStimulus();
      setReq(2, 5'd1);
      applyStimulus();
      setReq(2, 5'd17); setWrite(5'd2, 32'h2222);
      applyStimulus();
      checkOutput("t6b_b0_bz", 32'(bk_bz[0]), 32'h1);
      checkOutput("t6b_b0_vld", 32'(bk_vld[0]), 32'h0);
      checkOutput("t6b_pending", 32'(pending), 32'h04);
      applyStimulus();
      checkBank("t6b_ret", 2, 1'b1, 1'b0, 3'd2, 32'hC1);
      checkOutput("t6b_b0_noret", 32'(bk_vld[0]), 32'h0);
      checkOutput("t6b_pending_clr", 32'(pending), 32'h0);
      applyStimulus();
      checkOutput("t6b_no_dup_b0", 32'(bk_vld[0]), 32'h0);
      checkOutput("t6b_no_dup_b2", 32'(bk_vld[2]), 32'h0);

      // Reset mid-traffic with five requests pending, a return and a busy bank
      setWrite(5'd9, 32'h99);
      applyStimulus();
      setReq(7, 5'd9);
      applyStimulus();
      setReq(0, 5'd24); setReq(1, 5'd25); setReq(2, 5'd26); setReq(3, 5'd27); setReq(4, 5'd28);
      setWrite(5'd0, 32'h55);
      applyStimulus();
      checkBank("t1_pre_b1", 1, 1'b1, 1'b0, 3'd7, 32'h99);
      checkOutput("t1_pre_b0_bz", 32'(bk_bz[0]), 32'h1);
      checkOutput("t1_pre_pending", 32'(pending), 32'h1F);
      #2;
      rst = 1'b0;
      #1;
      checkOutput("t1_rst_pending", 32'(pending), 32'h0);
      for (int b = 0; b < 4; b++) checkBank("t1_rst_bank", b, 1'b0, 1'b0, 3'd0, 32'h0);
      applyStimulus();
      rst = 1'b1;
      setReq(0, 5'd9);
      applyStimulus();
      applyStimulus();
      checkBank("t1_rf_cleared", 1, 1'b1, 1'b0, 3'd0, 32'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
